// File: rtl/dcache_ctrl.sv
// Non-blocking data-cache controller.
// Hits answer from the cache array one cycle after acceptance. Misses park
// in a small MSHR file until memory returns the line. Stores write through
// to memory and into the array. A halt request drains the outstanding
// misses and then holds halt_done.
module dcache_ctrl #(
   parameter int MSHR_N = 4,
   parameter int LDID_W = 4
) (
   input  logic              clock,
   input  logic              reset,
   // load port
   input  logic              ld_req,
   input  logic [63:0]       ld_addr,
   input  logic [LDID_W-1:0] ld_id,
   output logic              ld_ready,
   output logic              ld_resp_valid,
   output logic [LDID_W-1:0] ld_resp_id,
   output logic [63:0]       ld_resp_data,
   // store port
   input  logic              st_req,
   input  logic [63:0]       st_addr,
   input  logic [63:0]       st_data,
   output logic              st_ready,
   // drain control
   input  logic              halt_req,
   output logic              halt_done,
   // cache array lookup
   output logic [21:0]       rd1_tag,
   output logic [6:0]        rd1_idx,
   input  logic [63:0]       rd1_data,
   input  logic              rd1_valid,
   // cache array fill write
   output logic              wr0_en,
   output logic [21:0]       wr0_tag,
   output logic [6:0]        wr0_idx,
   output logic [63:0]       wr0_data,
   // cache array store write
   output logic              wr1_en,
   output logic [21:0]       wr1_tag,
   output logic [6:0]        wr1_idx,
   output logic [63:0]       wr1_data,
   // memory port
   output logic [1:0]        proc2Dmem_command,
   output logic [63:0]       proc2Dmem_addr,
   output logic [63:0]       proc2Dmem_data,
   input  logic [3:0]        Dmem2proc_response,
   input  logic [3:0]        Dmem2proc_tag,
   input  logic [63:0]       Dmem2proc_data
);

   localparam int          IDX_W    = (MSHR_N > 1) ? $clog2(MSHR_N) : 1;
   localparam logic [63:0] BLK_MASK = ~64'd7;

   localparam logic [1:0] CMD_NONE  = 2'd0;
   localparam logic [1:0] CMD_LOAD  = 2'd1;
   localparam logic [1:0] CMD_STORE = 2'd2;

   typedef enum logic [1:0] {RUN, DRAIN, HALTED} ctrl_state_t;
   typedef enum logic [1:0] {FREE, WAIT_ISSUE, WAIT_DATA} ent_state_t;

   typedef struct packed {
      ent_state_t        st;
      logic [63:0]       addr;     // block-aligned miss address
      logic [LDID_W-1:0] id;
      logic [3:0]        mem_tag;
      logic              nofill;   // a younger store overtook this miss
   } mshr_t;

   ctrl_state_t state, state_next;
   mshr_t       mshr      [MSHR_N];
   mshr_t       mshr_next [MSHR_N];

   logic [63:0]       ld_blk, st_blk;
   logic              any_free, issue_found, fill_hit;
   logic [IDX_W-1:0]  free_idx, issue_idx, fill_idx;
   logic              ld_fire, st_sel, issue_go, all_free_next;
   logic              resp_valid_next;
   logic [LDID_W-1:0] resp_id_next;
   logic [63:0]       resp_data_next;

   assign ld_blk    = ld_addr & BLK_MASK;
   assign st_blk    = st_addr & BLK_MASK;
   assign rd1_tag   = ld_addr[31:10];
   assign rd1_idx   = ld_addr[9:3];
   assign halt_done = (state == HALTED);

   // Scan the registered MSHR file for a free slot, an issue candidate and a fill match.
   always_comb begin
      // NOTE: combinational blocks use blocking '=' and give every output a default first, so no latch is inferred.
      any_free    = 1'b0;
      free_idx    = '0;
      issue_found = 1'b0;
      issue_idx   = '0;
      fill_hit    = 1'b0;
      fill_idx    = '0;
      // Walk downward so the lowest matching index is the one left standing.
      for (int i = MSHR_N - 1; i >= 0; i--) begin
         if (mshr[i].st == FREE) begin
            any_free = 1'b1;
            free_idx = IDX_W'(i);
         end
         if (mshr[i].st == WAIT_ISSUE) begin
            issue_found = 1'b1;
            issue_idx   = IDX_W'(i);
         end
         if (mshr[i].st == WAIT_DATA && Dmem2proc_tag != 4'd0 &&
             mshr[i].mem_tag == Dmem2proc_tag) begin
            fill_hit = 1'b1;
            fill_idx = IDX_W'(i);
         end
      end
   end

   // Handshakes, memory-port arbitration (store before miss issue) and cache writes.
   always_comb begin
      // A returning tag blocks loads so a hit response never collides with a fill response.
      ld_ready          = (state == RUN) && (Dmem2proc_tag == 4'd0) && (rd1_valid || any_free);
      ld_fire           = ld_req && ld_ready;
      st_sel            = (state == RUN) && st_req;
      st_ready          = st_sel && (Dmem2proc_response != 4'd0);
      issue_go          = 1'b0;
      proc2Dmem_command = CMD_NONE;
      proc2Dmem_addr    = '0;
      proc2Dmem_data    = '0;
      if (st_sel) begin
         proc2Dmem_command = CMD_STORE;
         proc2Dmem_addr    = st_blk;
         proc2Dmem_data    = st_data;
      end else if (issue_found) begin
         proc2Dmem_command = CMD_LOAD;
         proc2Dmem_addr    = mshr[issue_idx].addr;
         issue_go          = (Dmem2proc_response != 4'd0);
      end

      wr1_en   = st_ready;
      wr1_tag  = st_ready ? st_addr[31:10] : '0;
      wr1_idx  = st_ready ? st_addr[9:3]   : '0;
      wr1_data = st_ready ? st_data        : '0;

      wr0_en   = fill_hit && !mshr[fill_idx].nofill;
      wr0_tag  = fill_hit ? mshr[fill_idx].addr[31:10] : '0;
      wr0_idx  = fill_hit ? mshr[fill_idx].addr[9:3]   : '0;
      wr0_data = fill_hit ? Dmem2proc_data             : '0;
   end

   // Next MSHR contents, next load response and next controller state.
   always_comb begin
      mshr_next  = mshr;
      state_next = state;

      if (fill_hit)
         mshr_next[fill_idx].st = FREE;

      if (issue_go) begin
         mshr_next[issue_idx].st      = WAIT_DATA;
         mshr_next[issue_idx].mem_tag = Dmem2proc_response;
      end

      // The array now holds newer data than the line in flight, so its fill must not land.
      if (st_ready) begin
         for (int i = 0; i < MSHR_N; i++) begin
            if (mshr[i].st != FREE && mshr[i].addr == st_blk)
               mshr_next[i].nofill = 1'b1;
         end
      end

      if (ld_fire && !rd1_valid)
         mshr_next[free_idx] = '{st: WAIT_ISSUE, addr: ld_blk, id: ld_id,
                                 mem_tag: 4'd0, nofill: 1'b0};

      resp_valid_next = 1'b0;
      resp_id_next    = '0;
      resp_data_next  = '0;
      if (ld_fire && rd1_valid) begin
         resp_valid_next = 1'b1;
         resp_id_next    = ld_id;
         resp_data_next  = rd1_data;
      end else if (fill_hit) begin
         resp_valid_next = 1'b1;
         resp_id_next    = mshr[fill_idx].id;
         resp_data_next  = Dmem2proc_data;
      end

      all_free_next = 1'b1;
      for (int i = 0; i < MSHR_N; i++) begin
         if (mshr_next[i].st != FREE)
            all_free_next = 1'b0;
      end

      case (state)
         RUN:     if (halt_req) state_next = DRAIN;
         DRAIN:   if (all_free_next) state_next = HALTED;
         default: state_next = state;
      endcase
   end

   // State, MSHR file and registered load response.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= RUN;
         // NOTE: the MSHR file is reset, unlike a data array, because entry status gates ld_ready straight out of reset.
         for (int i = 0; i < MSHR_N; i++)
            mshr[i] <= '{st: FREE, addr: '0, id: '0, mem_tag: '0, nofill: 1'b0};
         ld_resp_valid <= 1'b0;
         ld_resp_id    <= '0;
         ld_resp_data  <= '0;
      end else begin
         // NOTE: sequential state uses '<=' so every register samples pre-edge values.
         state         <= state_next;
         mshr          <= mshr_next;
         ld_resp_valid <= resp_valid_next;
         ld_resp_id    <= resp_id_next;
         ld_resp_data  <= resp_data_next;
      end
   end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: a behavioural cache array answers
// lookups, stimulus is cycle-scripted, and load responses are checked
// against a scoreboard queue filled when each response is provoked.
module tb_dcache_ctrl;

   localparam int LDID_W = 4;

   logic              clock = 1'b0;
   logic              reset = 1'b0;
   logic              ld_req;
   logic [63:0]       ld_addr;
   logic [LDID_W-1:0] ld_id;
   logic              ld_ready, ld_resp_valid;
   logic [LDID_W-1:0] ld_resp_id;
   logic [63:0]       ld_resp_data;
   logic              st_req, st_ready;
   logic [63:0]       st_addr, st_data;
   logic              halt_req, halt_done;
   logic [21:0]       rd1_tag;
   logic [6:0]        rd1_idx;
   logic [63:0]       rd1_data;
   logic              rd1_valid;
   logic              wr0_en, wr1_en;
   logic [21:0]       wr0_tag, wr1_tag;
   logic [6:0]        wr0_idx, wr1_idx;
   logic [63:0]       wr0_data, wr1_data;
   logic [1:0]        proc2Dmem_command;
   logic [63:0]       proc2Dmem_addr, proc2Dmem_data;
   logic [3:0]        Dmem2proc_response, Dmem2proc_tag;
   logic [63:0]       Dmem2proc_data;

   always #5 clock = ~clock;

   dcache_ctrl #(.MSHR_N(4), .LDID_W(LDID_W)) dut (
      .clock(clock), .reset(reset),
      .ld_req(ld_req), .ld_addr(ld_addr), .ld_id(ld_id), .ld_ready(ld_ready),
      .ld_resp_valid(ld_resp_valid), .ld_resp_id(ld_resp_id), .ld_resp_data(ld_resp_data),
      .st_req(st_req), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
      .halt_req(halt_req), .halt_done(halt_done),
      .rd1_tag(rd1_tag), .rd1_idx(rd1_idx), .rd1_data(rd1_data), .rd1_valid(rd1_valid),
      .wr0_en(wr0_en), .wr0_tag(wr0_tag), .wr0_idx(wr0_idx), .wr0_data(wr0_data),
      .wr1_en(wr1_en), .wr1_tag(wr1_tag), .wr1_idx(wr1_idx), .wr1_data(wr1_data),
      .proc2Dmem_command(proc2Dmem_command), .proc2Dmem_addr(proc2Dmem_addr),
      .proc2Dmem_data(proc2Dmem_data),
      .Dmem2proc_response(Dmem2proc_response), .Dmem2proc_tag(Dmem2proc_tag),
      .Dmem2proc_data(Dmem2proc_data)
   );

   // ---------------- cache array model ----------------
   bit          c_v    [128];
   logic [21:0] c_tag  [128];
   logic [63:0] c_data [128];
   logic        pre_en = 1'b0;
   logic [6:0]  pre_idx;
   logic [21:0] pre_tag;
   logic [63:0] pre_data;

   assign rd1_valid = c_v[rd1_idx] && (c_tag[rd1_idx] == rd1_tag);
   assign rd1_data  = c_data[rd1_idx];

   // Array writes land late in the cycle, after inputs settle and before the next rising edge.
   always @(negedge clock) begin
      #4;
      if (pre_en) begin c_v[pre_idx] = 1'b1; c_tag[pre_idx] = pre_tag; c_data[pre_idx] = pre_data; end
      if (wr0_en) begin c_v[wr0_idx] = 1'b1; c_tag[wr0_idx] = wr0_tag; c_data[wr0_idx] = wr0_data; end
      if (wr1_en) begin c_v[wr1_idx] = 1'b1; c_tag[wr1_idx] = wr1_tag; c_data[wr1_idx] = wr1_data; end
   end

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   typedef struct {
      logic [LDID_W-1:0] id;
      logic [63:0]       data;
   } resp_t;
   resp_t sb[$];

   task automatic sb_push(input logic [LDID_W-1:0] id, input logic [63:0] data);
      resp_t e;
      e.id   = id;
      e.data = data;
      sb.push_back(e);
   endtask

   // Response monitor: every ld_resp_valid must match the oldest expectation.
   always @(posedge clock) begin
      resp_t e;
      #2;
      if (ld_resp_valid === 1'b1) begin
         if (sb.size() == 0) begin
            check("resp_unexpected", 64'(ld_resp_id), 64'hFFFF);
         end else begin
            e = sb.pop_front();
            check("resp_id", 64'(ld_resp_id), 64'(e.id));
            check("resp_data", ld_resp_data, e.data);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic idle();
      ld_req = 1'b0; ld_addr = '0; ld_id = '0;
      st_req = 1'b0; st_addr = '0; st_data = '0;
      halt_req = 1'b0;
      Dmem2proc_response = '0; Dmem2proc_tag = '0; Dmem2proc_data = '0;
      pre_en = 1'b0;
   endtask

   task automatic cyc();
      @(negedge clock);
      idle();
   endtask

   function automatic logic [21:0] tag_of(input logic [63:0] a);
      return a[31:10];
   endfunction

   function automatic logic [6:0] idx_of(input logic [63:0] a);
      return a[9:3];
   endfunction

   function automatic logic [63:0] full_addr(input int k);
      return (64'(32'h200 + k) << 10) | (64'(40 + k) << 3);
   endfunction

   localparam logic [63:0] HIT5  = (64'h2A << 10) | (64'd5 << 3);
   localparam logic [63:0] HIT20 = (64'h33 << 10) | (64'd20 << 3);
   localparam logic [63:0] MISSA = 64'h1028;
   localparam logic [63:0] B_ADR = (64'h300 << 10) | (64'd60 << 3);
   localparam logic [63:0] X_ADR = ((64'h301 << 10) | (64'd61 << 3)) + 64'd2;
   localparam logic [63:0] M1    = (64'h400 << 10) | (64'd70 << 3);
   localparam logic [63:0] M2    = (64'h401 << 10) | (64'd71 << 3);
   localparam logic [63:0] M3    = (64'h500 << 10) | (64'd80 << 3);

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      idle();
      // ---- reset state ----
      reset = 1'b0;
      repeat (2) @(negedge clock);
      #1;
      check("rst_resp_valid", 64'(ld_resp_valid), 0);
      check("rst_halt_done", 64'(halt_done), 0);
      check("rst_cmd", 64'(proc2Dmem_command), 0);
      check("rst_wr0_en", 64'(wr0_en), 0);
      check("rst_wr1_en", 64'(wr1_en), 0);
      check("rst_st_ready", 64'(st_ready), 0);
      check("rst_ld_ready", 64'(ld_ready), 1);
      @(negedge clock);
      reset = 1'b1;

      // ---- hit ----
      cyc(); pre_en = 1'b1; pre_idx = 7'd5; pre_tag = 22'h2A; pre_data = 64'hDEAD_BEEF_0000_0005;
      cyc(); ld_req = 1'b1; ld_addr = HIT5; ld_id = 4'd3; #1;
      check("hit_ready", 64'(ld_ready), 1);
      check("hit_rd1_idx", 64'(rd1_idx), 5);
      check("hit_rd1_tag", 64'(rd1_tag), 64'h2A);
      check("hit_cmd", 64'(proc2Dmem_command), 0);
      sb_push(4'd3, 64'hDEAD_BEEF_0000_0005);
      cyc(); #1;
      check("hit_resp_valid", 64'(ld_resp_valid), 1);
      check("hit_cmd_after", 64'(proc2Dmem_command), 0);

      // ---- miss ----
      cyc(); ld_req = 1'b1; ld_addr = MISSA; ld_id = 4'd9; #1;
      check("miss_ready", 64'(ld_ready), 1);
      check("miss_cmd_alloc", 64'(proc2Dmem_command), 0);
      cyc(); Dmem2proc_response = 4'd7; #1;
      check("miss_cmd_load", 64'(proc2Dmem_command), 1);
      check("miss_addr", proc2Dmem_addr, 64'h1028);
      cyc(); #1;
      check("miss_cmd_wait", 64'(proc2Dmem_command), 0);
      cyc();
      cyc(); Dmem2proc_tag = 4'd7; Dmem2proc_data = 64'h1111_2222_3333_4444; #1;
      check("miss_wr0_en", 64'(wr0_en), 1);
      check("miss_wr0_idx", 64'(wr0_idx), 5);
      check("miss_wr0_tag", 64'(wr0_tag), 64'(tag_of(MISSA)));
      check("miss_wr0_data", wr0_data, 64'h1111_2222_3333_4444);
      check("miss_ld_ready_tag", 64'(ld_ready), 0);
      sb_push(4'd9, 64'h1111_2222_3333_4444);
      cyc(); #1;
      check("miss_resp_valid", 64'(ld_resp_valid), 1);
      check("miss_wr0_after", 64'(wr0_en), 0);

      // ---- full MSHR file ----
      for (int k = 0; k < 4; k++) begin
         cyc(); ld_req = 1'b1; ld_addr = full_addr(k); ld_id = LDID_W'(5 + k); #1;
         check("full_alloc_ready", 64'(ld_ready), 1);
      end
      cyc(); ld_req = 1'b1; ld_addr = full_addr(4); ld_id = 4'd9;
      pre_en = 1'b1; pre_idx = 7'd20; pre_tag = 22'h33; pre_data = 64'hCAFE_0000_0000_0020; #1;
      check("full_miss_ready", 64'(ld_ready), 0);
      check("full_retry_cmd", 64'(proc2Dmem_command), 1);
      check("full_retry_addr", proc2Dmem_addr, full_addr(0));
      cyc(); ld_req = 1'b1; ld_addr = HIT20; ld_id = 4'd12; #1;
      check("full_hit_ready", 64'(ld_ready), 1);
      sb_push(4'd12, 64'hCAFE_0000_0000_0020);
      cyc(); ld_req = 1'b1; ld_addr = HIT20; ld_id = 4'd13; Dmem2proc_tag = 4'hF; #1;
      check("full_tag_blocks_ready", 64'(ld_ready), 0);
      check("stray_tag_no_fill", 64'(wr0_en), 0);
      for (int k = 0; k < 4; k++) begin
         cyc(); Dmem2proc_response = 4'(k + 1); #1;
         check("full_issue_cmd", 64'(proc2Dmem_command), 1);
         check("full_issue_addr", proc2Dmem_addr, full_addr(k));
      end
      cyc(); #1;
      check("full_all_issued", 64'(proc2Dmem_command), 0);
      for (int k = 3; k >= 0; k--) begin
         cyc(); Dmem2proc_tag = 4'(k + 1); Dmem2proc_data = 64'hF000 + 64'(k); #1;
         check("full_fill_en", 64'(wr0_en), 1);
         check("full_fill_idx", 64'(wr0_idx), 64'(idx_of(full_addr(k))));
         sb_push(LDID_W'(5 + k), 64'hF000 + 64'(k));
      end
      cyc(); ld_addr = full_addr(4); #1;
      check("full_freed_ready", 64'(ld_ready), 1);

      // ---- store during miss ----
      cyc(); ld_req = 1'b1; ld_addr = B_ADR; ld_id = 4'd2; #1;
      check("st_miss_ready", 64'(ld_ready), 1);
      cyc(); st_req = 1'b1; st_addr = X_ADR; st_data = 64'h5A5A; #1;
      check("st_refused_cmd", 64'(proc2Dmem_command), 2);
      check("st_refused_ready", 64'(st_ready), 0);
      check("st_refused_wr1", 64'(wr1_en), 0);
      cyc(); st_req = 1'b1; st_addr = X_ADR; st_data = 64'h5A5A; Dmem2proc_response = 4'd5; #1;
      check("st_wins_cmd", 64'(proc2Dmem_command), 2);
      check("st_addr_aligned", proc2Dmem_addr, X_ADR & ~64'd7);
      check("st_mem_data", proc2Dmem_data, 64'h5A5A);
      check("st_ready", 64'(st_ready), 1);
      check("st_wr1_en", 64'(wr1_en), 1);
      check("st_wr1_idx", 64'(wr1_idx), 61);
      check("st_wr1_tag", 64'(wr1_tag), 64'h301);
      cyc(); Dmem2proc_response = 4'd6; #1;
      check("st_then_load_cmd", 64'(proc2Dmem_command), 1);
      check("st_then_load_addr", proc2Dmem_addr, B_ADR);
      cyc(); st_req = 1'b1; st_addr = B_ADR + 64'd4; st_data = 64'h7777; Dmem2proc_response = 4'd9; #1;
      check("st_same_blk_ready", 64'(st_ready), 1);
      check("st_same_blk_idx", 64'(wr1_idx), 60);
      cyc(); Dmem2proc_tag = 4'd6; Dmem2proc_data = 64'h6666_0000; #1;
      check("nofill_wr0_en", 64'(wr0_en), 0);
      sb_push(4'd2, 64'h6666_0000);
      cyc(); #1;
      check("nofill_resp_valid", 64'(ld_resp_valid), 1);

      // ---- halt with two misses pending ----
      cyc(); ld_req = 1'b1; ld_addr = M1; ld_id = 4'd11; #1;
      check("halt_m1_ready", 64'(ld_ready), 1);
      cyc(); ld_req = 1'b1; ld_addr = M2; ld_id = 4'd12; #1;
      check("halt_m2_ready", 64'(ld_ready), 1);
      cyc(); halt_req = 1'b1; Dmem2proc_response = 4'd1; #1;
      check("halt_issue_m1", proc2Dmem_addr, M1);
      check("halt_done_early", 64'(halt_done), 0);
      cyc(); Dmem2proc_response = 4'd2; st_req = 1'b1; st_addr = X_ADR; st_data = 64'h1;
      ld_req = 1'b1; ld_addr = HIT20; ld_id = 4'd14; #1;
      check("drain_ld_ready", 64'(ld_ready), 0);
      check("drain_st_ready", 64'(st_ready), 0);
      check("drain_wr1_en", 64'(wr1_en), 0);
      check("drain_issue_cmd", 64'(proc2Dmem_command), 1);
      check("drain_issue_addr", proc2Dmem_addr, M2);
      cyc(); Dmem2proc_tag = 4'd1; Dmem2proc_data = 64'hAAAA_0001; #1;
      check("drain_fill1_en", 64'(wr0_en), 1);
      check("drain_done_fill1", 64'(halt_done), 0);
      sb_push(4'd11, 64'hAAAA_0001);
      cyc(); Dmem2proc_tag = 4'd2; Dmem2proc_data = 64'hAAAA_0002; #1;
      check("drain_done_fill2", 64'(halt_done), 0);
      sb_push(4'd12, 64'hAAAA_0002);
      cyc(); #1;
      check("halted_done", 64'(halt_done), 1);
      cyc(); halt_req = 1'b1; ld_req = 1'b1; ld_addr = HIT20; #1;
      check("halted_hold", 64'(halt_done), 1);
      check("halted_ld_ready", 64'(ld_ready), 0);
      #2; reset = 1'b0; #1;
      check("async_rst_halt_done", 64'(halt_done), 0);

      // ---- reset with a miss in flight ----
      cyc(); reset = 1'b1;
      cyc(); ld_req = 1'b1; ld_addr = M3; ld_id = 4'd13; #1;
      check("rst_mid_ready", 64'(ld_ready), 1);
      cyc(); Dmem2proc_response = 4'd3; #1;
      check("rst_mid_issue", proc2Dmem_addr, M3);
      cyc(); #2; reset = 1'b0; #1;
      check("rst_mid_resp", 64'(ld_resp_valid), 0);
      cyc(); reset = 1'b1;
      cyc(); Dmem2proc_tag = 4'd3; Dmem2proc_data = 64'hBAD; #1;
      check("late_tag_wr0", 64'(wr0_en), 0);
      cyc(); #1;
      check("late_tag_resp", 64'(ld_resp_valid), 0);
      check("late_tag_cmd", 64'(proc2Dmem_command), 0);

      cyc(); #1;
      check("sb_empty", 64'(sb.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
